// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Owns the fetch PC, issues in-order requests to instruction memory with up to
// DEPTH requests outstanding, buffers returned words with their PCs in a
// DEPTH-entry queue, and hands them to decode over valid/ready. A redirect
// flushes the queue and drops every response still in flight.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response
// straight to decode when the queue is empty (saves one cycle of latency).
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   imem_req/addr/gnt         fetch request channel
//   imem_rvalid/rdata         in-order response channel
//   redirect_valid/pc         taken branch / jump target
//   instr_valid/ready/data/pc decode handshake
module fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         discard;

    logic [CW:0] credits_used;
    logic        issue;
    logic        rsp;
    logic        rsp_keep;
    logic        byp;
    logic        q_valid;
    logic        pop_q;
    logic        push;

    // Every queue slot is reserved at issue time, so a response always has
    // somewhere to land and the queue can never overflow.
    assign credits_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req     = rst && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
    assign imem_addr    = fetch_pc;
    assign issue        = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp      = imem_rvalid && (outstanding != '0);
    assign rsp_keep = rsp && (discard == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = rsp_keep && (count == '0) && !redirect_valid;
`else
    assign byp = 1'b0;
`endif

    assign q_valid     = (count != '0) && !redirect_valid;
    assign instr_valid = q_valid || byp;
    assign pop_q       = q_valid && instr_ready;
    // A bypassed word that decode takes this cycle never enters the queue.
    assign push        = rsp_keep && !redirect_valid && !(byp && instr_ready);

    // Empty queue drives zeros so the outputs are defined without resetting storage.
    always_comb begin
        instr_data = '0;
        instr_pc   = '0;
        if (byp) begin
            instr_data = imem_rdata;
            instr_pc   = resp_pc;
        end else if (count != '0) begin
            instr_data = q_data[rd_ptr];
            instr_pc   = q_pc[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old path; a response
            // arriving this very cycle is dropped here and not counted again.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            count       <= '0;
            rd_ptr      <= wr_ptr;
            outstanding <= outstanding - CW'(rsp);
            discard     <= outstanding - CW'(rsp);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            outstanding <= outstanding + CW'(issue) - CW'(rsp);
            if (rsp) begin
                if (discard != '0) begin
                    discard <= discard - CW'(1);
                end else begin
                    resp_pc <= resp_pc + ADDR_WIDTH'(4);
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

`ifndef SYNTHESIS
    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst) !(imem_rvalid && (outstanding == '0)));
`endif

endmodule
